// File: rtl/axis_8to32_packer.sv
// Packs an 8-bit AXI-Stream byte stream into 32-bit words with per-byte keep,
// closing a word on the fourth byte or on the packet's last byte.
module axis_8to32_packer #(
  parameter int BIG_ENDIAN = 0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  output logic [31:0]      m_data,
  output logic [3:0]       m_keep,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [CNT_W-1:0] pkt_count
);

  logic [31:0] r_asm_data;
  logic [3:0]  r_asm_keep;
  logic [1:0]  r_idx;

  logic [31:0]      r_m_data;
  logic [3:0]       r_m_keep;
  logic             r_m_valid;
  logic             r_m_last;
  logic [CNT_W-1:0] r_pkt_count;

  logic        w_s_ready;
  logic        w_accept;
  logic        w_complete;
  logic        w_drain;
  logic [1:0]  w_lane;
  logic [31:0] w_asm_data;
  logic [3:0]  w_asm_keep;

  assign w_s_ready  = !r_m_valid || m_ready;
  assign w_accept   = s_valid && w_s_ready;
  assign w_complete = w_accept && ((r_idx == 2'd3) || s_last);
  assign w_drain    = r_m_valid && m_ready;

  // Byte order within the word is mirrored in big-endian mode; keep follows the lanes.
  always_comb begin
    w_lane = r_idx;
    if (BIG_ENDIAN != 0) begin
      w_lane = 2'd3 - r_idx;
    end
    w_asm_data = r_asm_data | ({24'h000000, s_data} << {w_lane, 3'b000});
    w_asm_keep = r_asm_keep | (4'b0001 << w_lane);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_asm_data  <= '0;
      r_asm_keep  <= '0;
      r_idx       <= '0;
      r_m_data    <= '0;
      r_m_keep    <= '0;
      r_m_valid   <= 1'b0;
      r_m_last    <= 1'b0;
      r_pkt_count <= '0;
    end else begin
      if (w_complete) begin
        r_m_data   <= w_asm_data;
        r_m_keep   <= w_asm_keep;
        r_m_last   <= s_last;
        r_m_valid  <= 1'b1;
        r_asm_data <= '0;
        r_asm_keep <= '0;
        r_idx      <= '0;
      end else begin
        if (w_accept) begin
          r_asm_data <= w_asm_data;
          r_asm_keep <= w_asm_keep;
          r_idx      <= r_idx + 2'd1;
        end
        if (w_drain) begin
          r_m_valid <= 1'b0;
        end
      end
      if (w_drain && r_m_last) begin
        r_pkt_count <= r_pkt_count + 1'b1;
      end
    end
  end

  assign s_ready   = w_s_ready;
  assign m_data    = r_m_data;
  assign m_keep    = r_m_keep;
  assign m_valid   = r_m_valid;
  assign m_last    = r_m_last;
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_axis_8to32_packer.sv
// Directed bench for axis_8to32_packer: little-endian, big-endian and narrow-counter
// instances share one stimulus stream.
module tb_axis_8to32_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        m_ready;

  logic        s_ready_le, m_valid_le, m_last_le;
  logic [31:0] m_data_le;
  logic [3:0]  m_keep_le;
  logic [15:0] pkt_le;

  logic        s_ready_be, m_valid_be, m_last_be;
  logic [31:0] m_data_be;
  logic [3:0]  m_keep_be;
  logic [15:0] pkt_be;

  logic        s_ready_c2, m_valid_c2, m_last_c2;
  logic [31:0] m_data_c2;
  logic [3:0]  m_keep_c2;
  logic [1:0]  pkt_c2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_8to32_packer #(.BIG_ENDIAN(0), .CNT_W(16)) dut_le (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_le),
    .s_last(s_last), .m_data(m_data_le), .m_keep(m_keep_le), .m_valid(m_valid_le),
    .m_ready(m_ready), .m_last(m_last_le), .pkt_count(pkt_le)
  );

  axis_8to32_packer #(.BIG_ENDIAN(1), .CNT_W(16)) dut_be (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_be),
    .s_last(s_last), .m_data(m_data_be), .m_keep(m_keep_be), .m_valid(m_valid_be),
    .m_ready(m_ready), .m_last(m_last_be), .pkt_count(pkt_be)
  );

  axis_8to32_packer #(.BIG_ENDIAN(0), .CNT_W(2)) dut_c2 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_c2),
    .s_last(s_last), .m_data(m_data_c2), .m_keep(m_keep_c2), .m_valid(m_valid_c2),
    .m_ready(m_ready), .m_last(m_last_c2), .pkt_count(pkt_c2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic l);
    s_valid = 1'b1;
    s_data  = b;
    s_last  = l;
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic chk_word(input string tag, input logic [31:0] d, input logic [3:0] k,
                          input logic l);
    chk({tag, "_valid"}, {31'd0, m_valid_le}, 32'd1);
    chk({tag, "_data"},  m_data_le, d);
    chk({tag, "_keep"},  {28'd0, m_keep_le}, {28'd0, k});
    chk({tag, "_last"},  {31'd0, m_last_le}, {31'd0, l});
  endtask

  initial begin
    logic [31:0] held;
    rst = 1'b1; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_valid", {31'd0, m_valid_le}, 32'd0);
    chk("rst_data",  m_data_le, 32'd0);
    chk("rst_keep",  {28'd0, m_keep_le}, 32'd0);
    chk("rst_last",  {31'd0, m_last_le}, 32'd0);
    chk("rst_pkt",   {16'd0, pkt_le}, 32'd0);
    chk("rst_ready", {31'd0, s_ready_le}, 32'd1);

    // 4-byte packet
    m_ready = 1'b1;
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b1);
    chk_word("p4", 32'h44332211, 4'hF, 1'b1);
    chk("p4_be_data", m_data_be, 32'h11223344);
    tick();
    chk("p4_pkt", {16'd0, pkt_le}, 32'd1);
    chk("p4_drained", {31'd0, m_valid_le}, 32'd0);

    // 6-byte packet
    push(8'h11, 1'b0); push(8'h22, 1'b0); push(8'h33, 1'b0); push(8'h44, 1'b0);
    chk_word("p6w1", 32'h44332211, 4'hF, 1'b0);
    chk("p6w1_be_data", m_data_be, 32'h11223344);
    push(8'h55, 1'b0);
    chk("p6_gap_valid", {31'd0, m_valid_le}, 32'd0);
    push(8'h66, 1'b1);
    chk_word("p6w2", 32'h00006655, 4'h3, 1'b1);
    chk("p6w2_be_data", m_data_be, 32'h55660000);
    chk("p6w2_be_keep", {28'd0, m_keep_be}, 32'hC);
    tick();
    chk("p6_pkt", {16'd0, pkt_le}, 32'd2);

    // 1-byte packet
    push(8'hAB, 1'b1);
    chk_word("p1", 32'h000000AB, 4'h1, 1'b1);
    chk("p1_be_data", m_data_be, 32'hAB000000);
    chk("p1_be_keep", {28'd0, m_keep_be}, 32'h8);
    tick();
    chk("p1_pkt", {16'd0, pkt_le}, 32'd3);

    // 8-byte packet, one byte per cycle
    for (int i = 0; i < 8; i++) begin
      chk("b2b_ready", {31'd0, s_ready_le}, 32'd1);
      push(8'h81 + 8'(i), i == 7);
      if (i == 3) chk_word("b2b_w1", 32'h84838281, 4'hF, 1'b0);
      if (i == 4) chk("b2b_gap", {31'd0, m_valid_le}, 32'd0);
      if (i == 7) chk_word("b2b_w2", 32'h88878685, 4'hF, 1'b1);
    end
    tick();
    chk("b2b_pkt", {16'd0, pkt_le}, 32'd4);

    // Output stall with the next packet's byte waiting
    m_ready = 1'b0;
    push(8'hA1, 1'b0); push(8'hA2, 1'b0); push(8'hA3, 1'b0); push(8'hA4, 1'b0);
    chk_word("stall_w", 32'hA4A3A2A1, 4'hF, 1'b0);
    chk("stall_ready0", {31'd0, s_ready_le}, 32'd0);
    held = m_data_le;
    s_valid = 1'b1; s_data = 8'hB1; s_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_data", m_data_le, held);
      chk("stall_keep", {28'd0, m_keep_le}, 32'hF);
      chk("stall_last", {31'd0, m_last_le}, 32'd0);
      chk("stall_ready", {31'd0, s_ready_le}, 32'd0);
    end
    m_ready = 1'b1;
    #1;
    chk("stall_release_ready", {31'd0, s_ready_le}, 32'd1);
    tick();
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    chk_word("stall_next", 32'h000000B1, 4'h1, 1'b1);
    tick();
    chk("stall_pkt", {16'd0, pkt_le}, 32'd5);

    // Reset with a pending output word
    m_ready = 1'b0;
    push(8'hC1, 1'b0); push(8'hC2, 1'b0); push(8'hC3, 1'b0); push(8'hC4, 1'b1);
    chk("pend_valid", {31'd0, m_valid_le}, 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst2_valid", {31'd0, m_valid_le}, 32'd0);
    chk("rst2_pkt", {16'd0, pkt_le}, 32'd0);
    chk("rst2_ready", {31'd0, s_ready_le}, 32'd1);

    // Reset with two bytes partially assembled
    m_ready = 1'b1;
    push(8'hE1, 1'b0); push(8'hE2, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst3_valid", {31'd0, m_valid_le}, 32'd0);
    push(8'h01, 1'b0); push(8'h02, 1'b0); push(8'h03, 1'b0); push(8'h04, 1'b1);
    chk_word("post_rst", 32'h04030201, 4'hF, 1'b1);
    tick();
    chk("post_rst_pkt", {16'd0, pkt_le}, 32'd1);

    // Narrow counter wrap over five 1-byte packets
    rst = 1'b1; tick(); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      push(8'h10 + 8'(k), 1'b1);
      tick();
      chk("c2_pkt", {30'd0, pkt_c2}, 32'((k + 1) % 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
